cdb_complete_queue: RTL and testbench

Completion-side producer for the reorder buffer. Collects finished-instruction reports from the functional units, buffers them in a circular queue, and issues at most one completion per cycle as the ROB complete packet (`complete_en`, `complete_ROB_idx`) plus the physical tag for wakeup. On a branch rollback it squashes every buffered or arriving report younger than the rollback point, so the ROB never sees a completion for a flushed entry.

---
 rtl/cdb_complete_queue.sv | 136 +++++++++++++
 tb/tb_cdb_complete_queue.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/cdb_complete_queue.sv
// Completion queue feeding the ROB complete packet. Optional same-cycle bypass
// of an empty queue is enabled by defining CDB_BYPASS_EN.
module cdb_complete_queue #(
    parameter int NUM_FU  = 4,
    parameter int DEPTH   = 8,
    parameter int NUM_ROB = 32,
    parameter int NUM_PR  = 64
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic [NUM_FU-1:0]                  fu_done,
    input  logic [NUM_FU*$clog2(NUM_ROB)-1:0]  fu_ROB_idx,
    input  logic [NUM_FU*$clog2(NUM_PR)-1:0]   fu_T_idx,
    output logic [NUM_FU-1:0]                  fu_ready,
    input  logic [$clog2(NUM_ROB)-1:0]         ROB_head_idx,
    input  logic                               rollback_en,
    input  logic [$clog2(NUM_ROB)-1:0]         ROB_rollback_idx,
    output logic                               complete_en,
    output logic [$clog2(NUM_ROB)-1:0]         complete_ROB_idx,
    output logic [$clog2(NUM_PR)-1:0]          complete_T_idx
);
    localparam int RW = $clog2(NUM_ROB);
    localparam int TW = $clog2(NUM_PR);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0] slot_v;
    logic [RW-1:0]    slot_rob [DEPTH];
    logic [TW-1:0]    slot_t   [DEPTH];
    logic [PW-1:0]    head, tail;
    logic [CW-1:0]    count;

    logic [NUM_FU-1:0] acc, enq;
    logic [PW-1:0]     wr_slot [NUM_FU];
    logic [CW-1:0]     push_cnt;
    logic              pop;
    logic [RW-1:0]     rb_age;

    // Squash test: younger than the branch in ROB order relative to the head.
    function automatic logic is_young(input logic [RW-1:0] idx);
        logic [RW-1:0] age;
        age = idx - ROB_head_idx;
        return rollback_en && (age > rb_age);
    endfunction

    always_comb begin
        for (int unsigned i = 0; i < NUM_FU; i++)
            fu_ready[i] = (CW'(DEPTH) - count) > CW'(i);
    end

`ifdef CDB_BYPASS_EN
    logic          byp_en;
    logic [RW-1:0] byp_rob;
    logic [TW-1:0] byp_t;
    logic          byp_seen;
`endif

    always_comb begin
        rb_age = ROB_rollback_idx - ROB_head_idx;
        acc    = fu_done & fu_ready;
        enq    = acc;
        pop    = (count != '0);
`ifdef CDB_BYPASS_EN
        byp_en   = 1'b0;
        byp_rob  = '0;
        byp_t    = '0;
        byp_seen = 1'b0;
        // Only the first accepted report may bypass; a squashed one enqueues as a bubble.
        if (count == '0) begin
            for (int unsigned i = 0; i < NUM_FU; i++) begin
                if (acc[i] && !byp_seen) begin
                    byp_seen = 1'b1;
                    if (!is_young(fu_ROB_idx[i*RW +: RW])) begin
                        byp_en  = 1'b1;
                        byp_rob = fu_ROB_idx[i*RW +: RW];
                        byp_t   = fu_T_idx[i*TW +: TW];
                        enq[i]  = 1'b0;
                    end
                end
            end
        end
`endif
        push_cnt = '0;
        for (int unsigned i = 0; i < NUM_FU; i++) begin
            wr_slot[i] = tail + push_cnt[PW-1:0];
            if (enq[i])
                push_cnt = push_cnt + CW'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            slot_v           <= '0;
            head             <= '0;
            tail             <= '0;
            count            <= '0;
            complete_en      <= 1'b0;
            complete_ROB_idx <= '0;
            complete_T_idx   <= '0;
        end else begin
            for (int unsigned j = 0; j < DEPTH; j++)
                if (is_young(slot_rob[j]))
                    slot_v[j] <= 1'b0;
            // Written slots are always free, so they never collide with the squash above.
            for (int unsigned i = 0; i < NUM_FU; i++) begin
                if (enq[i]) begin
                    slot_v[wr_slot[i]]   <= !is_young(fu_ROB_idx[i*RW +: RW]);
                    slot_rob[wr_slot[i]] <= fu_ROB_idx[i*RW +: RW];
                    slot_t[wr_slot[i]]   <= fu_T_idx[i*TW +: TW];
                end
            end
            if (pop) begin
                if (slot_v[head] && !is_young(slot_rob[head])) begin
                    complete_en      <= 1'b1;
                    complete_ROB_idx <= slot_rob[head];
                    complete_T_idx   <= slot_t[head];
                end else begin
                    complete_en <= 1'b0;
                end
            end
`ifdef CDB_BYPASS_EN
            else if (byp_en) begin
                complete_en      <= 1'b1;
                complete_ROB_idx <= byp_rob;
                complete_T_idx   <= byp_t;
            end
`endif
            else begin
                complete_en <= 1'b0;
            end
            head  <= head + PW'(pop);
            tail  <= tail + push_cnt[PW-1:0];
            count <= count + push_cnt - CW'(pop);
        end
    end
endmodule

// File: tb/tb_cdb_complete_queue.sv
// Randomized and directed bench for cdb_complete_queue against a queue-based
// reference model of the completion rules (default build, no bypass).
module tb_cdb_complete_queue;
    localparam int DEPTH = 8;

    logic        clock = 1'b0;
    logic        reset;
    logic [3:0]  fu_done;
    logic [19:0] fu_ROB_idx;
    logic [23:0] fu_T_idx;
    logic [3:0]  fu_ready;
    logic [4:0]  ROB_head_idx;
    logic        rollback_en;
    logic [4:0]  ROB_rollback_idx;
    logic        complete_en;
    logic [4:0]  complete_ROB_idx;
    logic [5:0]  complete_T_idx;

    cdb_complete_queue #(.NUM_FU(4), .DEPTH(DEPTH), .NUM_ROB(32), .NUM_PR(64)) dut (
        .clock(clock), .reset(reset), .fu_done(fu_done), .fu_ROB_idx(fu_ROB_idx),
        .fu_T_idx(fu_T_idx), .fu_ready(fu_ready), .ROB_head_idx(ROB_head_idx),
        .rollback_en(rollback_en), .ROB_rollback_idx(ROB_rollback_idx),
        .complete_en(complete_en), .complete_ROB_idx(complete_ROB_idx),
        .complete_T_idx(complete_T_idx)
    );

    always #5 clock = ~clock;

    typedef struct { bit v; int rob; int t; } ent_t;
    ent_t mq[$];
    int   seen[$];
    int   n_checks = 0;
    int   n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic bit younger(input int x);
        int ax, ar;
        ax = (x - int'(ROB_head_idx) + 32) % 32;
        ar = (int'(ROB_rollback_idx) - int'(ROB_head_idx) + 32) % 32;
        return rollback_en && (ax > ar);
    endfunction

    task automatic offer(input int i, input int rob, input int t);
        fu_done[i] = 1'b1;
        fu_ROB_idx[i*5 +: 5] = 5'(rob);
        fu_T_idx[i*6 +: 6] = 6'(t);
    endtask

    // One clock: check readiness, advance the model, check the registered output.
    task automatic step();
        logic [3:0] er, acc;
        ent_t e;
        bit   exp_en;
        int   exp_rob, exp_t;
        er = '0;
        for (int i = 0; i < 4; i++) er[i] = (DEPTH - mq.size()) > i;
        #1;
        check("fu_ready", {28'd0, fu_ready}, {28'd0, er});
        acc = fu_done & er;
        exp_en = 0; exp_rob = 0; exp_t = 0;
        if (mq.size() > 0) begin
            e = mq.pop_front();
            if (e.v && !younger(e.rob)) begin
                exp_en = 1; exp_rob = e.rob; exp_t = e.t;
            end
        end
        if (rollback_en)
            foreach (mq[k]) if (younger(mq[k].rob)) mq[k].v = 0;
        for (int i = 0; i < 4; i++) begin
            if (acc[i]) begin
                e.rob = int'(fu_ROB_idx[i*5 +: 5]);
                e.t   = int'(fu_T_idx[i*6 +: 6]);
                e.v   = !younger(e.rob);
                mq.push_back(e);
            end
        end
        @(posedge clock); #1;
        check("complete_en", {31'd0, complete_en}, {31'd0, exp_en});
        if (exp_en) begin
            check("complete_ROB_idx", {27'd0, complete_ROB_idx}, exp_rob);
            check("complete_T_idx", {26'd0, complete_T_idx}, exp_t);
        end
        if (complete_en) seen.push_back(int'(complete_ROB_idx));
        fu_done = fu_done & ~acc;
    endtask

    task automatic drain(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    initial begin
        int offered, cyc;
        reset = 1'b0; fu_done = '0; fu_ROB_idx = '0; fu_T_idx = '0;
        ROB_head_idx = '0; rollback_en = 1'b0; ROB_rollback_idx = '0;
        #12;
        check("rst_en", {31'd0, complete_en}, 0);
        check("rst_rob", {27'd0, complete_ROB_idx}, 0);
        check("rst_t", {26'd0, complete_T_idx}, 0);
        check("rst_ready", {28'd0, fu_ready}, 32'hF);
        @(negedge clock); reset = 1'b1;
        @(posedge clock); #1;

        // single report: FU2, ROB 5, T 17
        offer(2, 5, 17);
        step();
        check("single_lat1", {31'd0, complete_en}, 0);
        step();
        check("single_en", {31'd0, complete_en}, 1);
        check("single_rob", {27'd0, complete_ROB_idx}, 5);
        check("single_t", {26'd0, complete_T_idx}, 17);
        step();
        check("single_off", {31'd0, complete_en}, 0);

        // burst: 12 reports offered, all must emerge in FU order
        seen.delete(); offered = 0; cyc = 0;
        while (offered < 12 || fu_done != 4'b0) begin
            for (int i = 0; i < 4; i++)
                if (!fu_done[i] && offered < 12) begin offer(i, offered, offered + 40); offered++; end
            if (cyc == 2) check("burst_ready_c2", {28'd0, fu_ready}, 32'h1);
            step();
            cyc++;
        end
        drain(10);
        check("burst_count", seen.size(), 12);
        for (int k = 0; k < seen.size() && k < 12; k++) check("burst_order", seen[k], k);
        check("burst_empty_ready", {28'd0, fu_ready}, 32'hF);

        // rollback: head 30, queue 31,1,4,2, rollback at 1
        seen.delete();
        ROB_head_idx = 5'd30;
        offer(0, 31, 1); offer(1, 1, 2); offer(2, 4, 3); offer(3, 2, 4);
        step();
        rollback_en = 1'b1; ROB_rollback_idx = 5'd1;
        step();
        rollback_en = 1'b0;
        drain(6);
        check("rb_count", seen.size(), 2);
        if (seen.size() >= 2) begin
            check("rb_first", seen[0], 31);
            check("rb_second", seen[1], 1);
        end

        // wrap: 20 single reports through the ring
        seen.delete();
        for (int k = 0; k < 20; k++) begin
            offer(k % 4, k + 3, k);
            step();
        end
        drain(4);
        check("wrap_count", seen.size(), 20);
        for (int k = 0; k < seen.size() && k < 20; k++) check("wrap_order", seen[k], (k + 3) % 32);

        // reset mid-operation
        for (int i = 0; i < 4; i++) offer(i, i + 10, i);
        step();
        #2 reset = 1'b0;
        #1;
        check("midrst_en", {31'd0, complete_en}, 0);
        check("midrst_ready", {28'd0, fu_ready}, 32'hF);
        mq.delete(); fu_done = '0;
        @(negedge clock); reset = 1'b1;
        @(posedge clock); #1;
        drain(3);

        // randomized traffic
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < 4; i++)
                if (!fu_done[i] && $urandom_range(0, 99) < 60)
                    offer(i, $urandom_range(0, 31), $urandom_range(0, 63));
            if ($urandom_range(0, 7) == 0) ROB_head_idx = 5'($urandom_range(0, 31));
            rollback_en = ($urandom_range(0, 9) == 0);
            ROB_rollback_idx = 5'($urandom_range(0, 31));
            step();
        end
        rollback_en = 1'b0;
        while (fu_done != 4'b0) step();
        drain(10);
        check("final_ready", {28'd0, fu_ready}, 32'hF);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
